// File: rtl/operand_issue_pkg.sv
// ============================================================================
// Module  : operand_issue_pkg
// Brief   : Micro-op encodings, instruction field positions and decode helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package operand_issue_pkg;

    localparam logic [4:0] UOP_NOP  = 5'd0;
    localparam logic [4:0] UOP_ADD  = 5'd1;
    localparam logic [4:0] UOP_SUB  = 5'd2;
    localparam logic [4:0] UOP_AND  = 5'd3;
    localparam logic [4:0] UOP_XOR  = 5'd4;
    localparam logic [4:0] UOP_CMP  = 5'd5;
    localparam logic [4:0] UOP_LSL  = 5'd6;
    localparam logic [4:0] UOP_LSR  = 5'd7;
    localparam logic [4:0] UOP_MOV  = 5'd8;
    localparam logic [4:0] UOP_LAST = 5'd8;

    localparam int OP_LSB  = 12;
    localparam int IMM_BIT = 11;
    localparam int RD_LSB  = 8;
    localparam int RN_LSB  = 5;
    localparam int RM_LSB  = 2;
    localparam int IMM_W   = 5;

    typedef struct packed {
        logic [4:0] uop;
        logic       wr_en;
        logic       use_rn;
        logic       use_rm;
        logic       zero_lhs;
        logic       zero_rhs;
        logic       illegal;
    } dec_t;

    // Op codes above UOP_LAST collapse to a NOP that reads and writes nothing.
    function automatic dec_t decode(input logic [15:0] instr);
        dec_t       d;
        logic [4:0] raw;
        logic       nop;
        logic       mov;
        raw        = {1'b0, instr[OP_LSB +: 4]};
        d.illegal  = raw > UOP_LAST;
        d.uop      = d.illegal ? UOP_NOP : raw;
        nop        = d.uop == UOP_NOP;
        mov        = d.uop == UOP_MOV;
        d.use_rn   = !nop && !mov;
        d.use_rm   = !instr[IMM_BIT] && !nop;
        d.wr_en    = !nop && (d.uop != UOP_CMP);
        d.zero_lhs = nop || mov;
        d.zero_rhs = nop;
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_issue_regfile.sv
// ============================================================================
// Module  : regfile_2r1w
// Brief   : Two async read ports, one write port, write-first read bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 2 ** AW;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/operand_issue.sv
// ============================================================================
// Module  : operand_issue
// Brief   : Decode/operand-fetch stage with RAW scoreboard feeding the ALU.
//           Optional performance counters under macro ISSUE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] lhs,
    output logic [DATA_W-1:0] rhs,
    output logic [4:0]        uop,
    output logic [REG_AW-1:0] rd,
    output logic              wr_en,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stalls
);

    localparam int NREG = 2 ** REG_AW;

    dec_t              dec;
    logic [REG_AW-1:0] rn_idx;
    logic [REG_AW-1:0] rm_idx;
    logic [REG_AW-1:0] rd_idx;
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] lhs_next;
    logic [DATA_W-1:0] rhs_next;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    logic              hazard;
    logic              accept;

    assign dec     = decode(instr);
    assign rn_idx  = instr[RN_LSB +: REG_AW];
    assign rm_idx  = instr[RM_LSB +: REG_AW];
    assign rd_idx  = instr[RD_LSB +: REG_AW];
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .AW     (REG_AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rn_idx),
        .rdata_a (rn_data),
        .raddr_b (rm_idx),
        .rdata_b (rm_data)
    );

    // A pending source is harmless if its writeback lands this very cycle.
    assign hazard = (dec.use_rn && pending[rn_idx] && !(wb_en && (wb_rd == rn_idx)))
                 || (dec.use_rm && pending[rm_idx] && !(wb_en && (wb_rd == rm_idx)));

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    assign lhs_next = dec.zero_lhs ? '0 : rn_data;
    assign rhs_next = dec.zero_rhs ? '0 : (instr[IMM_BIT] ? imm_ext : rm_data);

    always_comb begin
        pending_next = pending;
        if (wb_en) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (accept && dec.wr_en) begin
            pending_next[rd_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lhs       <= '0;
            rhs       <= '0;
            uop       <= UOP_NOP;
            rd        <= '0;
            wr_en     <= 1'b0;
            pending   <= '0;
            illegal   <= 1'b0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                out_valid <= 1'b1;
                lhs       <= lhs_next;
                rhs       <= rhs_next;
                uop       <= dec.uop;
                rd        <= rd_idx;
                wr_en     <= dec.wr_en;
                if (dec.illegal) begin
                    illegal <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (in_valid && hazard) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    assign perf_issued = '0;
    assign perf_stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_issue.sv
// ============================================================================
// Module  : tb_operand_issue
// Brief   : Directed scenarios plus random traffic against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  uop;
    logic [2:0]  rd;
    logic        wr_en;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        illegal;
    logic [31:0] perf_issued;
    logic [31:0] perf_stalls;

    always #5 clk = ~clk;

    operand_issue #(.DATA_W(32), .REG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .lhs(lhs), .rhs(rhs), .uop(uop), .rd(rd), .wr_en(wr_en),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .perf_issued(perf_issued), .perf_stalls(perf_stalls)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] m_regs [8];
    bit          m_pend [8];
    bit          m_ov, m_wr, m_ill;
    logic [31:0] m_lhs, m_rhs;
    logic [4:0]  m_uop;
    logic [2:0]  m_rd;
    int unsigned m_issued, m_stalls;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ov = 0; m_wr = 0; m_ill = 0; m_lhs = '0; m_rhs = '0; m_uop = '0; m_rd = '0;
        m_issued = 0; m_stalls = 0;
    endfunction

    function automatic logic [31:0] rdv(input logic [2:0] r);
        return (wb_en && wb_rd == r) ? wb_data : m_regs[r];
    endfunction

    function automatic logic [15:0] mk(input int op, input int i, input int d, input int n, input int m);
        logic [15:0] w;
        w = {op[3:0], i[0], d[2:0], n[2:0], 5'd0};
        if (i != 0) w[4:0] = m[4:0];
        else        w[4:2] = m[2:0];
        return w;
    endfunction

    // Drive one cycle of inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                        input logic we, input logic [2:0] wr, input logic [31:0] wd);
        int          op;
        bit          ill, nop, mov, use_n, use_m, wen, haz, rdy, acc;
        logic [4:0]  u;
        logic [2:0]  rn, rm;
        in_valid = v; instr = ins; out_ready = ordy;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        op    = int'(ins[15:12]);
        ill   = op > 8;
        u     = ill ? 5'd0 : 5'(op);
        nop   = (u == 0);
        mov   = (u == 8);
        rn    = ins[7:5];
        rm    = ins[4:2];
        use_n = !nop && !mov;
        use_m = !ins[11] && !nop;
        wen   = !nop && (u != 5);
        haz   = (use_n && m_pend[rn] && !(we && wr == rn)) ||
                (use_m && m_pend[rm] && !(we && wr == rm));
        rdy   = (!m_ov || ordy) && !haz;
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        acc = v && rdy;
        if (v && haz) m_stalls++;
        if (acc) begin
            m_ov  = 1;
            m_uop = u;
            m_rd  = ins[10:8];
            m_wr  = wen;
            m_lhs = (nop || mov) ? 32'd0 : rdv(rn);
            m_rhs = nop ? 32'd0 : (ins[11] ? {27'd0, ins[4:0]} : rdv(rm));
            if (ill) m_ill = 1;
            m_issued++;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (we) begin
            m_pend[wr] = 0;
            m_regs[wr] = wd;
        end
        if (acc && wen) m_pend[ins[10:8]] = 1;
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("lhs", lhs, m_lhs);
        check("rhs", rhs, m_rhs);
        check("uop", {27'd0, uop}, {27'd0, m_uop});
        check("rd", {29'd0, rd}, {29'd0, m_rd});
        check("wr_en", {31'd0, wr_en}, {31'd0, m_wr});
        check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    endtask

    task automatic check_perf(input string tag);
`ifdef ISSUE_PERF_EN
        check({tag, "_issued"}, perf_issued, m_issued);
        check({tag, "_stalls"}, perf_stalls, m_stalls);
`else
        check({tag, "_issued"}, perf_issued, 32'd0);
        check({tag, "_stalls"}, perf_stalls, 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_lhs", lhs, 32'd0);
        check("rst_uop", {27'd0, uop}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_perf("rst_perf");
        @(negedge clk);

        // Writeback R1=5, then ADD r2,r1,#3
        step(0, 16'h0, 1, 1, 3'd1, 32'd5);
        step(1, mk(1, 1, 2, 1, 3), 1, 0, 3'd0, 32'd0);
        check("add_lhs", lhs, 32'd5);
        check("add_rhs", rhs, 32'd3);
        check("add_uop", {27'd0, uop}, 32'd1);
        check("add_rd", {29'd0, rd}, 32'd2);

        // SUB r3,r2,r1 stalls on r2 until its writeback, then bypasses it
        step(1, mk(2, 0, 3, 2, 1), 1, 0, 3'd0, 32'd0);
        check("sub_stall", {31'd0, in_ready}, 32'd0);
        step(1, mk(2, 0, 3, 2, 1), 1, 1, 3'd2, 32'h77);
        check("sub_bypass_lhs", lhs, 32'h77);
        check("sub_rhs", rhs, 32'd5);

        // Backpressure: bundle held stable, in_ready low
        repeat (3) step(1, mk(4, 1, 6, 1, 1), 0, 0, 3'd0, 32'd0);
        check("hold_lhs", lhs, 32'h77);
        step(1, mk(4, 1, 6, 1, 1), 1, 0, 3'd0, 32'd0);
        check("xor_uop", {27'd0, uop}, 32'd4);

        // CMP and an illegal opcode
        step(1, mk(5, 0, 0, 1, 2), 1, 0, 3'd0, 32'd0);
        check("cmp_wr_en", {31'd0, wr_en}, 32'd0);
        step(1, mk(12, 0, 7, 1, 2), 1, 0, 3'd0, 32'd0);
        check("ill_uop", {27'd0, uop}, 32'd0);
        step(0, 16'h0, 1, 0, 3'd0, 32'd0);
        check("ill_sticky", {31'd0, illegal}, 32'd1);

        // Writeback r4 while MOV r4 issues: pending set wins, next reader stalls
        step(1, mk(8, 1, 4, 0, 7), 1, 1, 3'd4, 32'h99);
        step(1, mk(1, 1, 5, 4, 0), 0, 0, 3'd0, 32'd0);
        check("mov_pend_stall", {31'd0, in_ready}, 32'd0);

        // Reset while stalled with a held bundle
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_perf("midrst_perf");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [15:0] ins;
            ins = 16'($urandom_range(0, 65535));
            ins[15:12] = 4'($urandom_range(0, 9));
            step(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom());
        end
        check_perf("final_perf");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
